// File: rtl/pong_score_keeper_if.sv
// Signal bundle between the Pong game logic and the score keeper.
// The keeper takes the slave side; the ball/collision logic drives the master side.
interface pong_score_keeper_if;
    logic       start;
    logic       point_left;
    logic       point_right;
    logic [3:0] score_left;
    logic [7:0] score_right;
    logic [1:0] state;
    logic       freeze;
    logic       serve_left;
    logic [1:0] winner;

    modport master (
        output start, point_left, point_right,
        input  score_left, score_right, state, freeze, serve_left, winner
    );

    modport slave (
        input  start, point_left, point_right,
        output score_left, score_right, state, freeze, serve_left, winner
    );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong game-state and score controller: idle, serve delay, play, game over.
// Inputs are rising-edge detected; every output comes straight from a register.
module pong_score_keeper #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_CYCLES = 50000000
) (
    input logic                Clk,
    input logic                Rst,
    pong_score_keeper_if.slave bus
);
    localparam int unsigned     CntW     = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad  = CntW'(SERVE_CYCLES - 1);
    localparam logic [3:0]      WinScore = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StPlay  = 2'd2,
        StOver  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      score_l_q, score_l_d;
    logic [3:0]      score_r_q, score_r_d;
    logic [1:0]      winner_q, winner_d;
    logic            serve_left_q, serve_left_d;
    logic            freeze_q;
    logic            start_q, point_l_q, point_r_q;
    logic            rise_start, rise_l, rise_r;
    logic            new_game;

    assign rise_start = bus.start & ~start_q;
    assign rise_l     = bus.point_left & ~point_l_q;
    assign rise_r     = bus.point_right & ~point_r_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        winner_d     = winner_q;
        serve_left_d = serve_left_q;
        new_game     = 1'b0;

        unique case (state_q)
            StIdle, StOver: new_game = rise_start;
            StServe: begin
                if (rise_start) begin
                    new_game = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPlay: begin
                // Simultaneous points cancel; start is ignored mid-rally.
                if (rise_l ^ rise_r) begin
                    if (rise_l) begin
                        score_l_d    = score_l_q + 4'd1;
                        serve_left_d = 1'b0;
                    end else begin
                        score_r_d    = score_r_q + 4'd1;
                        serve_left_d = 1'b1;
                    end
                    if (rise_l && score_l_d == WinScore) begin
                        winner_d = 2'b01;
                        state_d  = StOver;
                    end else if (rise_r && score_r_d == WinScore) begin
                        winner_d = 2'b10;
                        state_d  = StOver;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StServe;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (new_game) begin
            score_l_d = '0;
            score_r_d = '0;
            winner_d  = 2'b00;
            cnt_d     = CntLoad;
            state_d   = StServe;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_q     <= 2'b00;
            serve_left_q <= 1'b0;
            freeze_q     <= 1'b1;
            start_q      <= 1'b0;
            point_l_q    <= 1'b0;
            point_r_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            winner_q     <= winner_d;
            serve_left_q <= serve_left_d;
            freeze_q     <= (state_d != StPlay);
            start_q      <= bus.start;
            point_l_q    <= bus.point_left;
            point_r_q    <= bus.point_right;
        end
    end

    assign bus.state       = state_q;
    assign bus.freeze      = freeze_q;
    assign bus.score_left  = score_l_q;
    assign bus.score_right = {4'b0000, score_r_q};
    assign bus.winner      = winner_q;
    assign bus.serve_left  = serve_left_q;
endmodule
